cache_req_arbiter: RTL
======================

Name: cache_req_arbiter

Overview:
Shares one lower-level cache port between NUM_REQ upper-level requesters, for example the L1I and L1D miss/evict ports feeding the shared L2.
Grants requesters round-robin and sequences each transaction: request issue, wait for the read fill, return the fill to the owner.
Only one transaction is in flight at a time. Writes (evictions) complete when the lower level accepts them; reads complete when the fill is accepted by the owner.

Parameters:
NUM_REQ, 2, number of upstream requesters (≥2).
ADDR_BITS, 64, address width.
B, 64, block size in bytes; data buses are B*8 bits.

Ports:
clk_in  in  1  clock; all logic on rising edge.
rst_N_in  in  1  reset, synchronous, active-low.
rq_valid_in  in  NUM_REQ  per-requester request valid.
rq_ready_out  out  NUM_REQ  per-requester request accept (one-hot or zero).
rq_addr_in  in  NUM_REQ*ADDR_BITS  request addresses; slice i = requester i.
rq_we_in  in  NUM_REQ  1 = block write (eviction), 0 = block read.
rq_value_in  in  NUM_REQ*B*8  write data; slice i = requester i.
rsp_valid_out  out  NUM_REQ  fill valid, one-hot to the owner.
rsp_ready_in  in  NUM_REQ  owner accepts fill.
rsp_addr_out  out  ADDR_BITS  block-aligned fill address (shared bus).
rsp_value_out  out  B*8  fill data (shared bus).
lc_valid_out  out  1  request to lower level.
lc_ready_in  in  1  lower level accepts request.
lc_addr_out  out  ADDR_BITS  block-aligned request address.
lc_value_out  out  B*8  write data.
lc_we_out  out  1  request is a write.
lc_valid_in  in  1  fill from lower level.
lc_ready_out  out  1  arbiter accepts fill.
lc_addr_in  in  ADDR_BITS  fill address.
lc_value_in  in  B*8  fill data.
busy_out  out  1  state ≠ IDLE.
stray_rsp_out  out  1  one-cycle pulse: a fill was accepted and dropped.

Behaviour:
- Transfer on any channel = valid && ready high at the same rising edge.
- Valid may not depend on ready. Once raised, a valid stays high with stable payload until the transfer.
- Reset: state=IDLE, rr_ptr=0, latched regs=0. All outputs 0 in the cycle after rst_N_in is sampled low.
- Reset mid-transaction abandons the transaction and drives no outputs. Recovery is the lower level's concern.
- All outputs decode from registered state/regs, except rq_ready_out, which is combinational from rq_valid_in in IDLE.
- IDLE:
  - g = first i with rq_valid_in[i], scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If any valid: rq_ready_out[g]=1. Latch owner=g, addr with low $clog2(B) bits zeroed, we, and value. Next state ISSUE.
- ISSUE:
  - lc_valid_out=1; lc_addr_out, lc_value_out and lc_we_out from latched regs.
  - On lc_ready_in: rr_ptr <= (owner+1) mod NUM_REQ. Next state IDLE if we=1, else WAIT_RESP.
- WAIT_RESP:
  - lc_ready_out=1.
  - On lc_valid_in with block-aligned lc_addr_in == latched addr: latch lc_value_in, next state RETURN.
  - On mismatch: the fill is consumed and dropped, stray_rsp_out=1 next cycle, state stays WAIT_RESP.
- RETURN:
  - rsp_valid_out[owner]=1; rsp_addr_out=latched addr; rsp_value_out=latched fill.
  - On rsp_ready_in[owner]: next state IDLE.
  - rsp_ready_in of non-owners is ignored.
- lc_ready_out=0 in all states except WAIT_RESP. lc_valid_out=0 except in ISSUE. rq_ready_out=0 except in IDLE.
- Latency:
  - Request accepted at edge t → lc_valid_out high from cycle t+1.
  - Fill accepted at edge k → rsp_valid_out high from cycle k+1.
  - Minimum read turnaround: 4 edges with an immediately-ready lower level and owner.
- Back-to-back: a new grant can occur in the IDLE cycle directly after a completion, so throughput is one write per 2 cycles.
- Fairness: after servicing i, requester i has lowest priority. A requester continuously asserting valid is granted within NUM_REQ transactions.
- Simultaneous valids in IDLE: exactly one is granted. Others hold valid and are considered next IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Unaligned request addresses are aligned on latch. Offset bits are never forwarded.

Test Plan:
1. Read, lone requester: req0 read addr 0x1048 → lc_addr_out=0x1040 next cycle. Fill {0x1040, D} → rsp_valid_out=2'b01, rsp_addr_out=0x1040, rsp_value_out=D. busy_out drops after rsp_ready_in[0].
2. Eviction: req1 write addr 0x2000, value V, with lc_ready_in held low 3 cycles → lc_valid_out/lc_we_out/lc_value_out=V stable 4 cycles. Then return to IDLE with no WAIT_RESP and lc_ready_out never high.
3. Fairness: both valid continuously, all reads → grants alternate 0,1,0,1. rr_ptr=0 after reset, so the first grant is 0.
4. Stray fill: in WAIT_RESP for 0x3000, fill arrives for 0x4000 → stray_rsp_out pulses once, no rsp_valid_out. The following fill for 0x3000 completes normally.
5. Owner backpressure: rsp_ready_in[0]=0 for 5 cycles → rsp_valid_out[0] and rsp_value_out held. rq_valid_in[1]=1 meanwhile gets no rq_ready_out until RETURN completes.
6. Reset mid-operation: rst_N_in low during ISSUE → the next cycle all outputs are 0, state is IDLE and rr_ptr=0. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one lower-level cache port among NUM_REQ requesters.
// One transaction in flight: issue, wait for a matching fill on reads, return it to the owner.
module cache_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 64,
  parameter int B         = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,
  input  logic [NUM_REQ-1:0]            rq_valid_in,
  output logic [NUM_REQ-1:0]            rq_ready_out,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  rq_addr_in,
  input  logic [NUM_REQ-1:0]            rq_we_in,
  input  logic [NUM_REQ*B*8-1:0]        rq_value_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  input  logic [NUM_REQ-1:0]            rsp_ready_in,
  output logic [ADDR_BITS-1:0]          rsp_addr_out,
  output logic [B*8-1:0]                rsp_value_out,
  output logic                          lc_valid_out,
  input  logic                          lc_ready_in,
  output logic [ADDR_BITS-1:0]          lc_addr_out,
  output logic [B*8-1:0]                lc_value_out,
  output logic                          lc_we_out,
  input  logic                          lc_valid_in,
  output logic                          lc_ready_out,
  input  logic [ADDR_BITS-1:0]          lc_addr_in,
  input  logic [B*8-1:0]                lc_value_in,
  output logic                          busy_out,
  output logic                          stray_rsp_out
);
  localparam int PW  = $clog2(NUM_REQ);
  localparam int OFF = $clog2(B);
  localparam int DW  = B * 8;
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~((ADDR_BITS'(1) << OFF) - ADDR_BITS'(1));

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_RETURN    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     w_gnt_idx;
  logic              w_gnt_any;
  logic [ADDR_BITS-1:0] r_addr;
  logic              r_we;
  logic [DW-1:0]     r_data;
  logic              r_stray;
  logic              w_grant;
  logic              w_lc_hs;
  logic              w_fill_hs;
  logic              w_fill_match;
  logic              w_rsp_hs;

  // Round-robin scan: first valid requester at or after r_rr_ptr
  always_comb begin
    logic [PW:0] v_idx;
    v_idx     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
      v_idx = (v_idx >= (PW+1)'(NUM_REQ)) ? (v_idx - (PW+1)'(NUM_REQ)) : v_idx;
      if (!w_gnt_any && rq_valid_in[v_idx[PW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = v_idx[PW-1:0];
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
  end

  assign w_grant      = (r_state == S_IDLE) && w_gnt_any && rst_N_in;
  assign w_lc_hs      = (r_state == S_ISSUE) && lc_ready_in;
  assign w_fill_hs    = (r_state == S_WAIT_RESP) && lc_valid_in;
  assign w_fill_match = ((lc_addr_in & ALIGN_MASK) == r_addr);
  assign w_rsp_hs     = (r_state == S_RETURN) && rsp_ready_in[r_owner];

  // Request accept is the only output not decoded from registers
  always_comb begin
    rq_ready_out = '0;
    if (w_grant) begin
      rq_ready_out[w_gnt_idx] = 1'b1;
    end else begin
      rq_ready_out = '0;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      w_next_state = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE:     w_next_state = w_lc_hs ? (r_we ? S_IDLE : S_WAIT_RESP) : S_ISSUE;
      S_WAIT_RESP: w_next_state = (w_fill_hs && w_fill_match) ? S_RETURN : S_WAIT_RESP;
      S_RETURN:    w_next_state = w_rsp_hs ? S_IDLE : S_RETURN;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Transaction latches, round-robin pointer and stray-fill pulse
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_data   <= '0;
      r_stray  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_addr  <= rq_addr_in[w_gnt_idx*ADDR_BITS +: ADDR_BITS] & ALIGN_MASK;
        r_we    <= rq_we_in[w_gnt_idx];
        r_data  <= rq_value_in[w_gnt_idx*DW +: DW];
      end else if (w_fill_hs && w_fill_match) begin
        r_data  <= lc_value_in;
      end
      if (w_lc_hs) begin
        r_rr_ptr <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : (r_owner + PW'(1));
      end
      r_stray <= w_fill_hs && !w_fill_match;
    end
  end

  // Owner-directed fill valid
  always_comb begin
    rsp_valid_out = '0;
    if (r_state == S_RETURN) begin
      rsp_valid_out[r_owner] = 1'b1;
    end else begin
      rsp_valid_out = '0;
    end
  end

  // Write data and fill data share r_data; state gating keeps idle buses at zero
  assign lc_valid_out  = (r_state == S_ISSUE);
  assign lc_addr_out   = lc_valid_out ? r_addr : '0;
  assign lc_value_out  = lc_valid_out ? r_data : '0;
  assign lc_we_out     = lc_valid_out & r_we;
  assign lc_ready_out  = (r_state == S_WAIT_RESP);
  assign rsp_addr_out  = (r_state == S_RETURN) ? r_addr : '0;
  assign rsp_value_out = (r_state == S_RETURN) ? r_data : '0;
  assign busy_out      = (r_state != S_IDLE);
  assign stray_rsp_out = r_stray;

endmodule
